// File: rtl/g_eth_pkg.sv
// Shared constants, state encoding and preamble decode for the GMII receive
// frame checker.
package g_eth_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;
  localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_DROP
  } rx_state_e;

  // Successor of a byte seen while hunting for the SFD.
  function automatic rx_state_e pre_next(input logic er, input logic [7:0] d);
    if (er)                 return ST_DROP;
    if (d == SFD_BYTE)      return ST_DATA;
    if (d == PREAMBLE_BYTE) return ST_PREAMBLE;
    return ST_DROP;
  endfunction

endpackage

// File: rtl/g_rx_crc32.sv
// Byte-wise CRC-32 register, MSB-first polynomial form, bit 0 of each byte
// consumed first (wire order). No output complement, so a good frame leaves
// the residue constant in the register.
module g_rx_crc32
  import g_eth_pkg::*;
(
  input  logic        gclk,
  input  logic        grst_n,
  input  logic        init_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init_i) begin
      crc_d = '1;
    end else if (en_i) begin
      for (int i = 0; i < 8; i++)
        crc_d = {crc_d[30:0], 1'b0} ^ ((crc_d[31] ^ data_i[i]) ? CRC_POLY : 32'h0);
    end
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) crc_q <= '1;
    else         crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/g_rx_fcs_check.sv
// GMII receive frame checker: strips preamble/SFD, checks the FCS, forwards
// payload through a 4-byte delay line and pulses a per-frame status.
module g_rx_fcs_check
  import g_eth_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Rx_dv,
  input  logic        Rx_er,
  input  logic [7:0]  Rxd,
  output logic [7:0]  Data_out,
  output logic        Data_valid,
  output logic        Sof,
  output logic        Status_valid,
  output logic        Frame_good,
  output logic        Frame_bad,
  output logic [15:0] Byte_cnt
);

  localparam logic [15:0] MIN_L = 16'(MIN_LEN);
  localparam logic [15:0] MAX_L = 16'(MAX_LEN);

  rx_state_e        state_q, state_d;
  logic             dv_q, err_q;
  logic [15:0]      cnt_q;
  logic [3:0][7:0]  dly_q;
  logic [7:0]       dout_q;
  logic             dval_q, sof_q, stv_q, good_q, bad_q;
  logic             start, accept, close, frame_ok;
  logic [31:0]      crc;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    close   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Rx_dv) state_d = dv_q ? ST_DROP : pre_next(Rx_er, Rxd);
      end
      ST_PREAMBLE: begin
        if (!Rx_dv) state_d = ST_IDLE;
        else        state_d = pre_next(Rx_er, Rxd);
      end
      ST_DATA: begin
        if (Rx_dv) begin
          accept = 1'b1;
        end else begin
          state_d = ST_IDLE;
          close   = 1'b1;
        end
      end
      ST_DROP: begin
        if (!Rx_dv) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign start    = (state_q != ST_DATA) && (state_d == ST_DATA);
  assign frame_ok = (crc == CRC_RESIDUE) && !err_q && (cnt_q >= MIN_L) && (cnt_q <= MAX_L);

  g_rx_crc32 u_crc (
    .gclk   (Clk),
    .grst_n (Reset_n),
    .init_i (start),
    .en_i   (accept),
    .data_i (Rxd),
    .crc_o  (crc)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // dv_q resets high so a frame already running at reset release reads as
  // "no rising edge" and is dropped.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      dv_q   <= 1'b1;
      err_q  <= 1'b0;
      cnt_q  <= '0;
      dly_q  <= '0;
      dout_q <= '0;
      dval_q <= 1'b0;
      sof_q  <= 1'b0;
      stv_q  <= 1'b0;
      good_q <= 1'b0;
      bad_q  <= 1'b0;
    end else begin
      dv_q   <= Rx_dv;
      dval_q <= 1'b0;
      sof_q  <= 1'b0;
      stv_q  <= 1'b0;
      good_q <= 1'b0;
      bad_q  <= 1'b0;
      if (start) begin
        cnt_q <= '0;
        err_q <= 1'b0;
      end
      if (accept) begin
        if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
        if (Rx_er)             err_q <= 1'b1;
        dly_q <= {dly_q[2:0], Rxd};
        // The last four bytes stay in the line, so the FCS is never forwarded.
        if (cnt_q >= 16'd4) begin
          dout_q <= dly_q[3];
          dval_q <= 1'b1;
          sof_q  <= (cnt_q == 16'd4);
        end
      end
      if (close) begin
        stv_q  <= 1'b1;
        good_q <= frame_ok;
        bad_q  <= !frame_ok;
      end
    end
  end

  assign Data_out     = dout_q;
  assign Data_valid   = dval_q;
  assign Sof          = sof_q;
  assign Status_valid = stv_q;
  assign Frame_good   = good_q;
  assign Frame_bad    = bad_q;
  assign Byte_cnt     = cnt_q;

endmodule

// File: doc/g_rx_fcs_check.md
# g_rx_fcs_check

Receive-side frame checker for the 1G Ethernet MAC; counterpart to the transmit CRC/FCS generator. Consumes GMII receive bytes, strips preamble/SFD, runs byte-wise CRC-32 over data+FCS, and forwards payload bytes with the 4 FCS bytes removed. At end of frame it issues a one-cycle status pulse with good/bad verdict and byte count for the RX FIFO/MAC control logic.

## Interface
Parameters:
- MIN_LEN, 64, minimum legal length in bytes after SFD, including FCS
- MAX_LEN, 1518, maximum legal length in bytes after SFD, including FCS

Ports:
- Clk  input  1  125 MHz GMII RX clock
- Reset_n  input  1  asynchronous, active-low reset
- Rx_dv  input  1  GMII RX_DV
- Rx_er  input  1  GMII RX_ER
- Rxd  input  8  GMII RXD, bit 0 first on wire
- Data_out  output  8  payload byte (FCS excluded)
- Data_valid  output  1  Data_out qualifier
- Sof  output  1  high with first Data_valid of a frame
- Status_valid  output  1  one-cycle end-of-frame pulse
- Frame_good  output  1  verdict, valid with Status_valid
- Frame_bad  output  1  inverse verdict, valid with Status_valid
- Byte_cnt  output  16  bytes after SFD incl. FCS, saturates at 16'hFFFF; valid with Status_valid

## Operation
- Clock is Clk; reset is asynchronous and active-low (Reset_n). All outputs reset to 0; state IDLE; CRC register all-ones; dv_d (registered Rx_dv) reset to 1, so a frame already in progress at reset release is ignored.
- States: IDLE, PREAMBLE, DATA, DROP.
- IDLE: Rx_dv=1 and dv_d=0 -> PREAMBLE (same byte evaluated as preamble byte). Rx_dv=1 and dv_d=1 -> DROP.
- PREAMBLE: Rxd=8'h55 stay; Rxd=8'hD5 -> DATA, CRC reset to all-ones, Byte_cnt cleared, error flag cleared; any other byte or Rx_er=1 -> DROP; Rx_dv=0 -> IDLE. No status in any of these cases.
- DATA, Rx_dv=1: byte fed to CRC (bit-reversed input, poly 0x04C11DB7), shifted into a 4-byte delay line, Byte_cnt incremented (saturating); Rx_er=1 sets sticky error flag.
- Delay line: once 4 bytes held, each new byte pushes the oldest out onto Data_out with Data_valid=1 next cycle; Sof=1 on the first such byte. FCS bytes therefore never appear on Data_out.
- DATA, Rx_dv=0: -> IDLE; next cycle Status_valid=1. Frame_good=1 iff CRC register == 32'hC704DD7B, error flag clear, MIN_LEN <= Byte_cnt <= MAX_LEN; else Frame_bad=1. Exactly one of Frame_good/Frame_bad high during Status_valid, both 0 otherwise.
- DROP: wait for Rx_dv=0 -> IDLE; no data, no status.
- Frame with fewer than 4 bytes after SFD: no Data_valid; status issued, Frame_bad=1.
- Over-length frame: forwarding continues; Frame_bad=1 at end.

## Timing
- Payload byte j (0-based after SFD) appears on Data_out the cycle after byte j+4 is sampled; latency 5 clocks from its own sampling.
- Status_valid: the cycle after Rx_dv first sampled low in DATA. Last Data_valid is in the cycle Rx_dv is sampled low... no later than one cycle before Status_valid.
- Back-to-back: Rx_dv rising in the Status_valid cycle is accepted (IFG of 1 cycle minimum); status of the previous frame is unaffected.
- Reset asserted mid-frame: outputs 0 immediately; no status for the aborted frame.

## Structure
- Package g_eth_pkg: PREAMBLE_BYTE 8'h55, SFD_BYTE 8'hD5, CRC_RESIDUE 32'hC704DD7B, CRC_POLY, state enum.
- Sub-module g_rx_crc32: byte-wise CRC-32 next-state logic + register with init/enable inputs; top holds FSM, delay line, counters.

## Test plan
- Good 64-byte frame (7x55, D5, 60 payload bytes 00..3B, model-computed FCS) -> 60 Data_valid bytes 00..3B, Sof on 00, Status_valid with Frame_good=1, Byte_cnt=64.
- Same frame with one payload bit flipped -> identical data forwarding, Frame_bad=1, Byte_cnt=64.
- Rx_er pulsed on payload byte 10 of a good frame -> Frame_bad=1; Rx_er during preamble -> no data, no Status_valid.
- Runt: SFD + 3 bytes -> no Data_valid, Frame_bad=1, Byte_cnt=3; 1519-byte frame with valid FCS -> Frame_bad=1, 1515 bytes forwarded.
- Bad preamble byte 8'h5D before SFD -> DROP, no output; next good frame after 1-cycle gap -> Frame_good=1.
- Reset_n released while Rx_dv=1 mid-frame -> frame ignored; Reset_n pulsed during DATA -> outputs 0, no status, next frame good.
